// File: rtl/mips_pkg.sv
// Shared types and defaults for the fetch front end.
package mips_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam int unsigned ADDR_W_DEFAULT   = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } ifq_state_t;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Instruction queue storage: DEPTH entries, wrap-bit pointers, synchronous clear.
module ifq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;

  // Status flags and pointer advance; clear wins over any push or pop.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    occupancy = CNT_W'(wr_ptr_q - rd_ptr_q);
    rd_data   = mem_q[rd_ptr_q[PTR_W-1:0]];
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en)          wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      if (rd_en && !empty) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are meaningless outside the pointer window.
  always_ff @(posedge clk) begin
    if (wr_en && !clear && !reset) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
    end
  end

  // The credit scheme upstream must never push into a full queue.
  always_ff @(posedge clk) begin
    if (!reset && !clear) begin
      assert (!(wr_en && full));
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: issues in-order word reads, buffers returns with
// their PC, hands them to decode, and flushes on redirect.
// Optional same-cycle response bypass when IFETCH_BYPASS_EN is defined.
module ifetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_req_ready,
  input  logic                mem_rsp_valid,
  input  logic [INSTR_W-1:0]  mem_rsp_data,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  input  logic                instr_ready
);

  localparam int unsigned CNT_W   = cnt_width(DEPTH);
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  ifq_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   ret_pc_q, ret_pc_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic [CNT_W-1:0]    discard_q, discard_d;

  logic                req_valid_c;
  logic                req_fire;
  logic                rsp_take;
  logic                rsp_accept;
  logic                bypass_c;
  logic                push;
  logic                pop;
  logic [CNT_W:0]      inflight_total;
  logic [ADDR_W-1:0]   redirect_pc_aligned;

  logic                fifo_empty;
  logic [CNT_W-1:0]    occupancy;
  logic [ENTRY_W-1:0]  head;

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .wr_en     (push),
    .wr_data   ({ret_pc_q, mem_rsp_data}),
    .rd_en     (pop),
    .rd_data   (head),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  // Handshake decode: request credit, response acceptance, bypass and queue ports.
  always_comb begin
    redirect_pc_aligned = redirect_pc & ~ADDR_W'(3);
    inflight_total      = (CNT_W+1)'(occupancy) + (CNT_W+1)'(outstanding_q);
    req_valid_c         = !reset && (state_q == FETCH) &&
                          (inflight_total < (CNT_W+1)'(DEPTH));
    req_fire            = req_valid_c && mem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_take            = !reset && mem_rsp_valid && (outstanding_q != '0);
    rsp_accept          = rsp_take && (discard_q == '0) && !redirect;
`ifdef IFETCH_BYPASS_EN
    bypass_c            = fifo_empty && rsp_accept;
`else
    bypass_c            = 1'b0;
`endif
    push                = rsp_accept && !(bypass_c && instr_ready);
    pop                 = !reset && !fifo_empty && instr_ready;

    mem_req_valid       = req_valid_c;
    mem_req_addr        = fetch_pc_q;
    instr_valid         = !reset && (!fifo_empty || bypass_c);
    instr               = bypass_c ? mem_rsp_data : head[INSTR_W-1:0];
    instr_pc            = bypass_c ? ret_pc_q     : head[ENTRY_W-1:INSTR_W];
  end

  // Next-state: PCs, in-flight/discard accounting and FETCH/DRAIN selection.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    ret_pc_d      = ret_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
    if (redirect) begin
      fetch_pc_d = redirect_pc_aligned;
      ret_pc_d   = redirect_pc_aligned;
      // Everything still in flight after this edge belongs to the old path.
      discard_d  = outstanding_d;
    end else begin
      if (req_fire)   fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (rsp_accept) ret_pc_d   = ret_pc_q + ADDR_W'(4);
      if (rsp_take && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
    end
    state_d = (discard_d != '0) ? DRAIN : FETCH;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      ret_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      ret_pc_q      <= ret_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Memory must not return more words than were requested.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(mem_rsp_valid && (outstanding_q == '0)));
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a queue-based reference model.
module tb_ifetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  ifetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; int due; } pend_t;
  typedef struct packed { logic [31:0] pc; logic stale; } infl_t;

  // memory stimulus side
  pend_t       pending[$];
  int          lat;
  int          cyc;
  // reference model: requests in flight (oldest first) and buffered PCs
  infl_t       m_infl[$];
  logic [31:0] m_q[$];
  logic [31:0] m_fetch_pc;
  // expectations for the current cycle
  logic        e_req, e_rsp_ok, e_byp, e_ivalid;
  logic [31:0] e_ipc;
  // samples taken before the edge
  logic        s_req_hs, s_pop_hs, s_rsp;
  logic [31:0] s_addr, s_ipc;
  // observed handshakes
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_mem();
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(pending[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
    end
  endtask

  task automatic settle();
    drive_mem();
    #1;
  endtask

  // What the outputs must be, from the buffered/in-flight picture.
  task automatic compute_exp();
    logic stale_front;
    stale_front = (m_infl.size() > 0) && m_infl[0].stale;
    e_req    = !reset && !stale_front && (m_q.size() + m_infl.size() < DEPTH);
    e_rsp_ok = !reset && mem_rsp_valid && (m_infl.size() > 0) && !stale_front && !redirect;
    e_byp    = BYP && (m_q.size() == 0) && e_rsp_ok;
    e_ivalid = !reset && ((m_q.size() > 0) || e_byp);
    if (m_q.size() > 0)         e_ipc = m_q[0];
    else if (m_infl.size() > 0) e_ipc = m_infl[0].pc;
    else                        e_ipc = 32'h0;
  endtask

  task automatic compare();
    chk("req_valid", 32'(mem_req_valid), 32'(e_req));
    if (e_req) chk("req_addr", mem_req_addr, m_fetch_pc);
    chk("instr_valid", 32'(instr_valid), 32'(e_ivalid));
    if (e_ivalid) begin
      chk("instr_pc", instr_pc, e_ipc);
      chk("instr", instr, mem_word(e_ipc));
    end
  endtask

  task automatic model_update();
    infl_t it;
    if (reset) begin
      m_infl.delete();
      m_q.delete();
      m_fetch_pc = RESET_PC;
    end else begin
      if (e_ivalid && instr_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (mem_rsp_valid && m_infl.size() > 0) begin
        it = m_infl.pop_front();
        if (e_rsp_ok && !(e_byp && instr_ready)) m_q.push_back(it.pc);
      end
      if (e_req && mem_req_ready) begin
        it.pc    = m_fetch_pc;
        it.stale = redirect;
        m_infl.push_back(it);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (redirect) begin
        m_q.delete();
        foreach (m_infl[i]) m_infl[i].stale = 1'b1;
        m_fetch_pc = redirect_pc & ~32'h3;
      end
    end
  endtask

  // One clock: check, sample, advance memory and model, then back to negedge.
  task automatic cycle();
    pend_t p;
    settle();
    compute_exp();
    compare();
    s_req_hs = mem_req_valid && mem_req_ready && !reset;
    s_addr   = mem_req_addr;
    s_pop_hs = instr_valid && instr_ready && !reset;
    s_ipc    = instr_pc;
    s_rsp    = mem_rsp_valid;
    @(posedge clk);
    if (s_rsp) void'(pending.pop_front());
    if (s_req_hs) begin
      p.addr = s_addr;
      p.due  = cyc + lat;
      pending.push_back(p);
      req_log.push_back(s_addr);
    end
    if (s_pop_hs) pop_log.push_back(s_ipc);
    model_update();
    cyc++;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
    pending.delete();
  endtask

  task automatic start(input int l);
    lat = l;
    instr_ready   = 1'b1;
    mem_req_ready = 1'b1;
    req_log.delete();
    pop_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    instr_ready = 1'b1; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    lat = 1; cyc = 0; m_fetch_pc = RESET_PC;
    @(negedge clk);
    settle();
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    do_reset(2);

    // 1: streaming, 1-cycle memory
    start(1);
    repeat (12) cycle();
    chk("s1_req0", at(req_log, 0), 32'h0);
    chk("s1_req1", at(req_log, 1), 32'h4);
    chk("s1_req2", at(req_log, 2), 32'h8);
    chk("s1_pop0", at(pop_log, 0), 32'h0);
    chk("s1_pop1", at(pop_log, 1), 32'h4);
    chk("s1_pop2", at(pop_log, 2), 32'h8);
    chk("s1_pops", 32'(pop_log.size()), BYP ? 32'd11 : 32'd10);
    do_reset(2);

    // 2: decode stalled, credit limit, then release
    start(1);
    instr_ready = 1'b0;
    repeat (10) cycle();
    settle();
    chk("s2_nreq", 32'(req_log.size()), 32'd4);
    chk("s2_req_stop", 32'(mem_req_valid), 32'd0);
    instr_ready = 1'b1;
    repeat (12) cycle();
    chk("s2_pop0", at(pop_log, 0), 32'h0);
    chk("s2_pop1", at(pop_log, 1), 32'h4);
    chk("s2_pop2", at(pop_log, 2), 32'h8);
    chk("s2_pop3", at(pop_log, 3), 32'hC);
    chk("s2_resume", at(req_log, 4), 32'h10);
    do_reset(2);

    // 3: redirect with two reads in flight, 3-cycle memory
    start(3);
    cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    cycle();
    settle();
    chk("s3_drain_req", 32'(mem_req_valid), 32'd0);
    repeat (13) cycle();
    chk("s3_req_new", at(req_log, 2), 32'h100);
    chk("s3_pop_first", at(pop_log, 0), 32'h100);
    do_reset(2);

    // 4: redirect coinciding with a response and a pop
    start(1);
    repeat (3) cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    cycle();
    settle();
    chk("s4_empty", 32'(instr_valid), 32'd0);
    chk("s4_popped_pc", at(pop_log, 1), 32'h4);
    chk("s4_npop", 32'(pop_log.size()), 32'd2);
    repeat (8) cycle();
    chk("s4_after", at(pop_log, 2), 32'h200);
    do_reset(2);

    // 5: address wrap at the top of the range
    start(1);
    mem_req_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    mem_req_ready = 1'b1;
    repeat (8) cycle();
    chk("s5_req0", at(req_log, 0), 32'hFFFF_FFF8);
    chk("s5_req1", at(req_log, 1), 32'hFFFF_FFFC);
    chk("s5_req2", at(req_log, 2), 32'h0000_0000);
    chk("s5_pop2", at(pop_log, 2), 32'h0000_0000);
    do_reset(2);

    // 6: reset while draining; stale returns land during reset
    start(3);
    cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    cycle();
    cycle();
    settle();
    chk("s6_drain_req", 32'(mem_req_valid), 32'd0);
    do_reset(3);
    settle();
    chk("s6_req_valid", 32'(mem_req_valid), 32'd1);
    chk("s6_req_addr", mem_req_addr, RESET_PC);
    req_log.delete();
    pop_log.delete();
    repeat (10) cycle();
    chk("s6_pop0", at(pop_log, 0), RESET_PC);
    chk("s6_req1", at(req_log, 1), RESET_PC + 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
